// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end: fetch FSM states,
// the reset NOP and the instruction field positions used by decode.
package mips_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDrain
    } fetch_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned IMM_W   = 16;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds instr/pc4/valid and slices the rs/rt/imm
// fields for decode. Flush beats load; with neither asserted it holds.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_instr,
    input  logic [WIDTH-1:0] i_pc4,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_pc4,
    output logic [DEPTH-1:0] o_rs,
    output logic [DEPTH-1:0] o_rt,
    output logic [15:0]      o_imm
);

    logic             r_valid;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc4;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_instr <= WIDTH'(NOP_INSTR);
            r_pc4   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_rs    = r_instr[RS_LSB +: DEPTH];
    assign o_rt    = r_instr[RT_LSB +: DEPTH];
    assign o_imm   = r_instr[IMM_LSB +: IMM_W];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ready handshake, stall and redirect.
// Define FETCH_PERF_EN to add the fetch_count performance counter output.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 5,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             id_valid,
    output logic [WIDTH-1:0] id_instr,
    output logic [WIDTH-1:0] id_pc4,
    output logic [DEPTH-1:0] id_rs,
    output logic [DEPTH-1:0] id_rt,
    output logic [15:0]      id_imm
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      fetch_count
`endif
);

    fetch_state_t     r_state, w_state_next;
    logic [WIDTH-1:0] r_pc, w_pc_next;
    logic [WIDTH-1:0] r_pending, w_pending_next;
    logic [WIDTH-1:0] r_drain_addr, w_drain_addr_next;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_load_instr;
    logic             w_load;
    logic             w_flush;

    assign w_target   = branch_target & ~WIDTH'(3);
    assign w_pc_plus4 = r_pc + WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_pc         <= RESET_PC;
            r_pending    <= WIDTH'(NOP_INSTR);
            r_drain_addr <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_pending    <= w_pending_next;
            r_drain_addr <= w_drain_addr_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_pending_next    = r_pending;
        w_drain_addr_next = r_drain_addr;
        w_load            = 1'b0;
        w_flush           = 1'b0;
        w_load_instr      = imem_rdata;
        unique case (r_state)
            StIdle: begin
                if (branch_taken) w_pc_next = w_target;
                w_state_next = StFetch;
            end
            StFetch: begin
                if (branch_taken) begin
                    w_flush   = 1'b1;
                    w_pc_next = w_target;
                    // Request is still outstanding: wait it out at the old address.
                    if (!imem_ready) begin
                        w_state_next      = StDrain;
                        w_drain_addr_next = r_pc;
                    end
                end else if (imem_ready) begin
                    if (stall) begin
                        w_pending_next = imem_rdata;
                        w_state_next   = StHold;
                    end else begin
                        w_load    = 1'b1;
                        w_pc_next = w_pc_plus4;
                    end
                end
            end
            StHold: begin
                if (branch_taken) begin
                    w_flush      = 1'b1;
                    w_pc_next    = w_target;
                    w_state_next = StFetch;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_instr = r_pending;
                    w_pc_next    = w_pc_plus4;
                    w_state_next = StFetch;
                end
            end
            StDrain: begin
                if (branch_taken) w_pc_next = w_target;
                if (imem_ready) w_state_next = StFetch;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign imem_req  = (r_state == StFetch) || (r_state == StDrain);
    assign imem_addr = (r_state == StDrain) ? r_drain_addr : r_pc;

    if_id_reg #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_if_id (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_instr (w_load_instr),
        .i_pc4   (w_pc_plus4),
        .o_valid (id_valid),
        .o_instr (id_instr),
        .o_pc4   (id_pc4),
        .o_rs    (id_rs),
        .o_rt    (id_rt),
        .o_imm   (id_imm)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns 0x0123_0000 + address.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [15:0] id_imm;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'h0123_0000 + imem_addr;

    fetch_stage #(
        .WIDTH    (32),
        .DEPTH    (5),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc4        (id_pc4),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_imm        (id_imm)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_pc4", id_pc4, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        check("rst_count", fetch_count, 32'd0);
`endif
        rst = 1'b0;

        // Zero-wait streaming from reset
        step();
        check("s_req", 32'(imem_req), 32'd1);
        check("s_addr0", imem_addr, 32'h0);
        check("s_valid0", 32'(id_valid), 32'd0);
        step();
        check("s_valid1", 32'(id_valid), 32'd1);
        check("s_instr1", id_instr, 32'h0123_0000);
        check("s_pc4_1", id_pc4, 32'h4);
        check("s_rs", 32'(id_rs), 32'd9);
        check("s_rt", 32'(id_rt), 32'd3);
        check("s_imm", 32'(id_imm), 32'h0);
        check("s_addr1", imem_addr, 32'h4);
        step();
        check("s_pc4_2", id_pc4, 32'h8);
        check("s_addr2", imem_addr, 32'h8);
        step();
        check("s_pc4_3", id_pc4, 32'hC);
        check("s_addr3", imem_addr, 32'hC);
        step();
        check("s_addr4", imem_addr, 32'h10);

        // Memory waits three cycles at 0x10
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("w_req", 32'(imem_req), 32'd1);
            check("w_addr", imem_addr, 32'h10);
            check("w_pc4", id_pc4, 32'h10);
        end
        imem_ready = 1'b1;
        step();
        check("w_instr", id_instr, 32'h0123_0010);
        check("w_imm", 32'(id_imm), 32'h10);
        check("w_pc4_done", id_pc4, 32'h14);
        check("w_addr_done", imem_addr, 32'h14);

        // Stall while data returns: HOLD for 4 cycles
        stall = 1'b1;
        step();
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("h_req", 32'(imem_req), 32'd0);
            check("h_instr", id_instr, 32'h0123_0010);
            check("h_pc4", id_pc4, 32'h14);
            if (i < 3) step();
        end
        stall = 1'b0;
        step();
        check("h_release_instr", id_instr, 32'h0123_0014);
        check("h_release_pc4", id_pc4, 32'h18);
        check("h_release_addr", imem_addr, 32'h18);
        check("h_release_req", 32'(imem_req), 32'd1);

        // Stall with no handshake: IF/ID holds
        stall = 1'b1;
        step();
        check("ns_valid", 32'(id_valid), 32'd1);
        check("ns_pc4", id_pc4, 32'h18);
        check("ns_addr", imem_addr, 32'h18);
        stall = 1'b0;
        imem_ready = 1'b1;
        step();
        step();
        check("ns_addr2", imem_addr, 32'h20);

        // Redirect while waiting at 0x20 -> DRAIN
        imem_ready = 1'b0;
        step();
        branch_taken = 1'b1;
        branch_target = 32'h103;
        step();
        branch_taken = 1'b0;
        check("d_valid", 32'(id_valid), 32'd0);
        check("d_req", 32'(imem_req), 32'd1);
        check("d_addr", imem_addr, 32'h20);
        step();
        check("d_addr_wait", imem_addr, 32'h20);
        imem_ready = 1'b1;
        step();
        check("d_valid_after", 32'(id_valid), 32'd0);
        check("d_new_addr", imem_addr, 32'h100);
        step();
        check("d_instr", id_instr, 32'h0123_0100);
        check("d_pc4", id_pc4, 32'h104);

        // Redirect together with stall and ready: flush wins
        branch_taken = 1'b1;
        branch_target = 32'h40;
        stall = 1'b1;
        step();
        branch_taken = 1'b0;
        stall = 1'b0;
        check("f_valid", 32'(id_valid), 32'd0);
        check("f_addr", imem_addr, 32'h40);
        check("f_req", 32'(imem_req), 32'd1);
        step();
        check("f_instr", id_instr, 32'h0123_0040);
        check("f_pc4", id_pc4, 32'h44);

        // Redirect while in HOLD drops the pending word
        stall = 1'b1;
        step();
        branch_taken = 1'b1;
        branch_target = 32'h82;
        step();
        branch_taken = 1'b0;
        stall = 1'b0;
        check("hb_valid", 32'(id_valid), 32'd0);
        check("hb_addr", imem_addr, 32'h80);
        step();
        check("hb_instr", id_instr, 32'h0123_0080);
        check("hb_pc4", id_pc4, 32'h84);

        // Asynchronous reset in the middle of HOLD
        stall = 1'b1;
        step();
        check("r_hold_req", 32'(imem_req), 32'd0);
        check("r_hold_valid", 32'(id_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("r_req", 32'(imem_req), 32'd0);
        check("r_valid", 32'(id_valid), 32'd0);
        check("r_instr", id_instr, 32'h0);
        check("r_pc4", id_pc4, 32'h0);
        check("r_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        check("r_count", fetch_count, 32'd0);
`endif
        stall = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("r_restart_addr", imem_addr, 32'h0);
        check("r_restart_req", 32'(imem_req), 32'd1);
        step();
        check("r_restart_instr", id_instr, 32'h0123_0000);
        check("r_restart_pc4", id_pc4, 32'h4);

        // PC+4 wraps at the top of the address space
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wr_instr", id_instr, 32'h0122_FFFC);
        check("wr_pc4", id_pc4, 32'h0);
        check("wr_next", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the MIPS pipeline, directly upstream of `Decode`. It owns the program counter and runs a req/ready handshake with instruction memory. Fetched words go into the IF/ID pipeline register, which drives `Decode`'s `Reg1`/`Reg2`/`Inmediate` fields. It honours a decode stall and a branch redirect/flush.

## Interface
- `WIDTH`, 32, datapath/instruction width
- `DEPTH`, 5, register-specifier width
- `RESET_PC`, 32'h0000_0000, PC value held in reset
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  decode cannot accept a new instruction this cycle
- `branch_taken`  in  1  single-cycle redirect/flush pulse
- `branch_target`  in  WIDTH  redirect address; bits [1:0] ignored (forced 00)
- `imem_req`  out  1  fetch request
- `imem_addr`  out  WIDTH  fetch address (= PC)
- `imem_ready`  in  1  memory completes the request; `imem_rdata` valid this cycle
- `imem_rdata`  in  WIDTH  instruction word
- `id_valid`  out  1  IF/ID holds a live instruction
- `id_instr`  out  WIDTH  IF/ID instruction
- `id_pc4`  out  WIDTH  PC+4 of that instruction
- `id_rs`, `id_rt`  out  DEPTH  `id_instr[25:21]`, `id_instr[20:16]`
- `id_imm`  out  16  `id_instr[15:0]`

## Operation
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: entered in reset. `imem_req`=0. Moves to FETCH on the first clock after `rst` deasserts.
- FETCH:
  - `imem_req`=1, `imem_addr`=PC.
  - Once raised, `imem_req` stays high until `imem_ready`.
  - On `imem_ready` with `stall`=0: load IF/ID with `imem_rdata` and PC+4, set `id_valid`, PC<=PC+4, stay in FETCH.
  - On `imem_ready` with `stall`=1: capture the word in a pending register and go to HOLD.
- HOLD:
  - `imem_req`=0. IF/ID is unchanged.
  - When `stall` falls: move pending to IF/ID, PC<=PC+4, go to FETCH.
- Stall with no handshake: IF/ID holds its value. `id_valid` is unchanged.
- Redirect (`branch_taken`=1) has priority over stall and over every state:
  - `id_valid`<=0 and PC<={target[WIDTH-1:2],2'b00}.
  - FETCH with `imem_ready`=1 the same cycle: discard the data, stay in FETCH.
  - FETCH waiting (`imem_ready`=0): go to DRAIN.
  - HOLD: discard pending, go to FETCH.
  - IDLE: only PC is updated.
- DRAIN:
  - `imem_req`=1, `imem_addr`=the old address.
  - On `imem_ready`: discard the data, go to FETCH at the new PC.
  - A further `branch_taken` in DRAIN only updates PC.
- PC+4 wraps modulo 2^WIDTH.

## Timing
- Reset values:
  - PC=`RESET_PC`
  - `imem_req`=0, `id_valid`=0
  - `id_instr`=0 (sll NOP), `id_pc4`=0
  - State=IDLE
- Memory latency: zero wait states allowed (`imem_ready` in the same cycle as `imem_req`), giving a sustained 1 instruction/cycle.
- Latency: a word accepted at edge N appears on the `id_*` outputs after edge N.
- Redirect: `id_valid` is low the cycle after the `branch_taken` edge. The first request to the target issues that same cycle, or after DRAIN completes.
- `rst` mid-request abandons the request. The memory must tolerate `imem_req` dropping on reset.

## Configuration
- `FETCH_PERF_EN` defined: adds output `fetch_count` [31:0].
  - Reset 0.
  - Increments on every load of a valid instruction into IF/ID.
  - Discarded words are not counted.
  - Wraps at 2^32.
- `FETCH_PERF_EN` undefined: the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- Package `mips_pkg`:
  - `fetch_state_t` enum
  - `NOP_INSTR` constant (32'h0)
  - instruction field bit positions for rs/rt/imm
- One sub-module `if_id_reg`: holds instr/pc4/valid, with load, hold and flush controls. The field slicing lives here.

## Test plan
- Reset release, `imem_ready`=1 every cycle, `RESET_PC`=0 -> `imem_addr` 0,4,8,…; `id_pc4` 4,8,12; `id_valid` high from the 2nd cycle after release.
- `imem_ready` delayed 3 cycles at PC=0x10 -> `imem_req`/`imem_addr` held steady; `id_instr` loads once; PC becomes 0x14.
- `stall` high for 4 cycles while data returns -> HOLD; `imem_req`=0; IF/ID unchanged; the word appears the cycle after `stall` falls.
- `branch_taken` to 0x103 while waiting on PC 0x20 -> DRAIN; the returned word is discarded; next request at 0x100; no stale `id_valid`.
- `branch_taken` together with `stall` and `imem_ready` -> flush wins; `id_valid`=0; next `imem_addr`=target.
- `rst` asserted mid-HOLD -> all outputs return to their reset values asynchronously; fetch restarts at `RESET_PC` (with `FETCH_PERF_EN`: `fetch_count`=0).
